// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single port of the word memory between the instruction-fetch path
// (read-only) and the load/store path (read/write). Every access runs through
// IDLE -> ACCESS -> DONE. The memory-side outputs are plain registers that are
// loaded when a request is accepted and cleared when ACCESS ends. They are
// therefore steady across the falling edge where the memory commits a write,
// and the asynchronous reset drops them immediately.
//
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   : round-robin between the two ports when both request
//   undefined : fixed priority, the data port wins (fetch may starve)
//
// Ports
//   clock, reset_n                 clock (rising edge), async active-low reset
//   i_req, i_addr                  fetch request/address (held until i_ack)
//   i_ack, i_rdata, i_err          fetch ack pulse, registered data / range error
//   d_req, d_we, d_addr, d_wdata   load/store request (held until d_ack)
//   d_ack, d_rdata, d_err          load/store ack pulse, registered data / error
//   mem_write_enabled, mem_read_enabled, mem_address, mem_wdata  to memory
//   mem_rdata                      from memory (combinational read)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int WORD_SIZE   = 32,
    parameter int MEMORY_SIZE = 1024
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic                 i_ack,
    output logic [WORD_SIZE-1:0] i_rdata,
    output logic                 i_err,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_ack,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_err,
    output logic                 mem_write_enabled,
    output logic                 mem_read_enabled,
    output logic [WORD_SIZE-1:0] mem_address,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [WORD_SIZE-1:0] MAX_ADDR = WORD_SIZE'(MEMORY_SIZE - 1);
    localparam logic [WORD_SIZE-1:0] ZERO_WORD = {WORD_SIZE{1'b0}};

    // Unsigned full-width range check.
    function automatic logic addr_out_of_range(input logic [WORD_SIZE-1:0] addr);
        return (addr > MAX_ADDR);
    endfunction

    state_t                 state_r;
    logic                   grant_data_r;   // 1 = current access belongs to the data port
    logic                   oor_r;          // latched address was out of range
    logic                   we_r;           // latched store flag
    logic                   mem_we_r;
    logic                   mem_re_r;
    logic [WORD_SIZE-1:0]   mem_addr_r;     // latched address, visible during ACCESS only
    logic [WORD_SIZE-1:0]   mem_wdata_r;    // latched store data, visible during ACCESS only
    logic                   i_ack_r;
    logic                   d_ack_r;
    logic [WORD_SIZE-1:0]   i_rdata_r;
    logic [WORD_SIZE-1:0]   d_rdata_r;
    logic                   i_err_r;
    logic                   d_err_r;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic                   last_grant_r;   // 0 = FETCH, 1 = DATA
`endif

    logic                   grant_data_s;
    logic [WORD_SIZE-1:0]   sel_addr_s;
    logic [WORD_SIZE-1:0]   sel_wdata_s;
    logic                   sel_we_s;
    logic                   sel_oor_s;

    // Winner selection while in IDLE.
    always_comb begin
        grant_data_s = 1'b0;
        if (d_req && i_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            grant_data_s = ~last_grant_r;
`else
            grant_data_s = 1'b1;
`endif
        end else if (d_req) begin
            grant_data_s = 1'b1;
        end else begin
            grant_data_s = 1'b0;
        end
    end

    // Values latched for the winner; fetch never carries write data or a write.
    always_comb begin
        sel_addr_s  = ZERO_WORD;
        sel_wdata_s = ZERO_WORD;
        sel_we_s    = 1'b0;
        if (grant_data_s) begin
            sel_addr_s  = d_addr;
            sel_wdata_s = d_wdata;
            sel_we_s    = d_we;
        end else begin
            sel_addr_s  = i_addr;
            sel_wdata_s = ZERO_WORD;
            sel_we_s    = 1'b0;
        end
        sel_oor_s = addr_out_of_range(sel_addr_s);
    end

    // Access sequencer: arbitration, memory-side registers, result capture, acks.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            grant_data_r <= 1'b0;
            oor_r        <= 1'b0;
            we_r         <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_re_r     <= 1'b0;
            mem_addr_r   <= ZERO_WORD;
            mem_wdata_r  <= ZERO_WORD;
            i_ack_r      <= 1'b0;
            d_ack_r      <= 1'b0;
            i_rdata_r    <= ZERO_WORD;
            d_rdata_r    <= ZERO_WORD;
            i_err_r      <= 1'b0;
            d_err_r      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    i_ack_r <= 1'b0;
                    d_ack_r <= 1'b0;
                    if (i_req || d_req) begin
                        grant_data_r <= grant_data_s;
                        oor_r        <= sel_oor_s;
                        we_r         <= sel_we_s;
                        mem_addr_r   <= sel_addr_s;
                        mem_wdata_r  <= sel_wdata_s;
                        mem_re_r     <= 1'b1;
                        // An out-of-range store is turned into a plain read.
                        mem_we_r     <= sel_we_s & ~sel_oor_s;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_grant_r <= grant_data_s;
`endif
                        state_r      <= ST_ACCESS;
                    end else begin
                        state_r      <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    // mem_rdata still shows the pre-write word here.
                    if (grant_data_r) begin
                        d_rdata_r <= oor_r ? ZERO_WORD : mem_rdata;
                        d_err_r   <= oor_r;
                        d_ack_r   <= 1'b1;
                    end else begin
                        i_rdata_r <= oor_r ? ZERO_WORD : mem_rdata;
                        i_err_r   <= oor_r;
                        i_ack_r   <= 1'b1;
                    end
                    mem_we_r    <= 1'b0;
                    mem_re_r    <= 1'b0;
                    mem_addr_r  <= ZERO_WORD;
                    mem_wdata_r <= ZERO_WORD;
                    we_r        <= 1'b0;
                    state_r     <= ST_DONE;
                end
                ST_DONE: begin
                    i_ack_r <= 1'b0;
                    d_ack_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    i_ack_r     <= 1'b0;
                    d_ack_r     <= 1'b0;
                    mem_we_r    <= 1'b0;
                    mem_re_r    <= 1'b0;
                    mem_addr_r  <= ZERO_WORD;
                    mem_wdata_r <= ZERO_WORD;
                    we_r        <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign i_ack             = i_ack_r;
    assign i_rdata           = i_rdata_r;
    assign i_err             = i_err_r;
    assign d_ack             = d_ack_r;
    assign d_rdata           = d_rdata_r;
    assign d_err             = d_err_r;
    // we_r is kept alongside mem_we_r; the final gate cannot widen a write.
    assign mem_write_enabled = mem_we_r & we_r;
    assign mem_read_enabled  = mem_re_r;
    assign mem_address       = mem_addr_r;
    assign mem_wdata         = mem_wdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. A table of single accesses is applied
// and compared in a loop. Hand-written sequences cover reset, contention, and
// reset during a store.
//
// Memory model: 1024 words, preset to 32'hA5000000 | index, and word 7 preset
// to 32'h12345678. A write is decided at the falling edge and becomes visible
// after the next rising edge, so a store reads back the pre-write word.
// Addresses that are out of range read as 32'hBAD0BAD0.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clock;
    logic        reset_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_write_enabled;
    logic        mem_read_enabled;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit DATA_FIRST = 1'b0;
`else
    localparam bit DATA_FIRST = 1'b1;
`endif

    mem_port_arbiter #(.WORD_SIZE(32), .MEMORY_SIZE(1024)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .i_req             (i_req),
        .i_addr            (i_addr),
        .i_ack             (i_ack),
        .i_rdata           (i_rdata),
        .i_err             (i_err),
        .d_req             (d_req),
        .d_we              (d_we),
        .d_addr            (d_addr),
        .d_wdata           (d_wdata),
        .d_ack             (d_ack),
        .d_rdata           (d_rdata),
        .d_err             (d_err),
        .mem_write_enabled (mem_write_enabled),
        .mem_read_enabled  (mem_read_enabled),
        .mem_address       (mem_address),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- memory model ----------------
    logic [31:0] mem [0:1023];
    bit          mem_ready;
    bit          pend_v;
    logic [9:0]  pend_a;
    logic [31:0] pend_d;
    int          write_count = 0;
    int          oor_write_count = 0;

    assign mem_rdata = (mem_address < 32'd1024) ? mem[mem_address[9:0]] : 32'hBAD0BAD0;

    always @(negedge clock) begin
        pend_v <= 1'b0;
        if (mem_write_enabled) begin
            write_count <= write_count + 1;
            if (mem_address < 32'd1024) begin
                pend_v <= 1'b1;
                pend_a <= mem_address[9:0];
                pend_d <= mem_wdata;
            end else begin
                oor_write_count <= oor_write_count + 1;
            end
        end
    end

    always @(posedge clock) begin
        if (!mem_ready) begin
            for (int k = 0; k < 1024; k++) mem[k] <= 32'hA5000000 | 32'(k);
            mem[7]    <= 32'h12345678;
            mem_ready <= 1'b1;
        end else if (pend_v) begin
            mem[pend_a] <= pend_d;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        is_data;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_writes;
    } vec_t;

    vec_t        vecs[12];
    logic [31:0] exp_i_rdata = 32'h0;
    logic [31:0] exp_d_rdata = 32'h0;

    // One access from an IDLE negedge; returns at the next IDLE negedge.
    task automatic do_access(input vec_t v);
        int  wc0;
        int  cyc;
        bit  got;
        wc0 = write_count;
        cyc = 0;
        got = 1'b0;
        if (v.is_data) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge clock);
            if (c == 1) begin
                // Inputs change mid-access; the latched values must be used.
                d_addr = ~d_addr; d_wdata = ~d_wdata; i_addr = ~i_addr;
            end
            if (v.is_data ? d_ack : i_ack) begin
                got = 1'b1;
                cyc = c;
            end
        end
        check({v.name, " latency"}, 32'(cyc), 32'd2);
        if (got) begin
            if (v.is_data) begin
                exp_d_rdata = v.exp_rdata;
                check({v.name, " d_rdata"}, d_rdata, v.exp_rdata);
                check({v.name, " d_err"}, {31'd0, d_err}, {31'd0, v.exp_err});
                check({v.name, " i_ack idle"}, {31'd0, i_ack}, 32'd0);
                check({v.name, " i_rdata hold"}, i_rdata, exp_i_rdata);
            end else begin
                exp_i_rdata = v.exp_rdata;
                check({v.name, " i_rdata"}, i_rdata, v.exp_rdata);
                check({v.name, " i_err"}, {31'd0, i_err}, {31'd0, v.exp_err});
                check({v.name, " d_ack idle"}, {31'd0, d_ack}, 32'd0);
                check({v.name, " d_rdata hold"}, d_rdata, exp_d_rdata);
            end
            check({v.name, " mem_re in DONE"}, {31'd0, mem_read_enabled}, 32'd0);
            check({v.name, " writes"}, 32'(write_count - wc0), 32'(v.exp_writes));
        end
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
        @(negedge clock);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        vec_t v;
        int   d_cyc;
        int   i_cyc;
        int   wc0;
        bit   any_ack;

        vecs[0]  = '{"st5",        1'b1, 1'b1, 32'd5,        32'hDEADBEEF, 32'hA5000005, 1'b0, 1};
        vecs[1]  = '{"ld5",        1'b1, 1'b0, 32'd5,        32'h0,        32'hDEADBEEF, 1'b0, 0};
        vecs[2]  = '{"if7",        1'b0, 1'b0, 32'd7,        32'h0,        32'h12345678, 1'b0, 0};
        vecs[3]  = '{"if1023",     1'b0, 1'b0, 32'd1023,     32'h0,        32'hA50003FF, 1'b0, 0};
        vecs[4]  = '{"ld1023",     1'b1, 1'b0, 32'd1023,     32'h0,        32'hA50003FF, 1'b0, 0};
        vecs[5]  = '{"st1024",     1'b1, 1'b1, 32'd1024,     32'hFFFFFFFF, 32'h0,        1'b1, 0};
        vecs[6]  = '{"ld1024",     1'b1, 1'b0, 32'd1024,     32'h0,        32'h0,        1'b1, 0};
        vecs[7]  = '{"ifFFFFFFFF", 1'b0, 1'b0, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b1, 0};
        vecs[8]  = '{"if0",        1'b0, 1'b0, 32'd0,        32'h0,        32'hA5000000, 1'b0, 0};
        vecs[9]  = '{"st1023",     1'b1, 1'b1, 32'd1023,     32'hCAFEF00D, 32'hA50003FF, 1'b0, 1};
        vecs[10] = '{"ld1023b",    1'b1, 1'b0, 32'd1023,     32'h0,        32'hCAFEF00D, 1'b0, 0};
        vecs[11] = '{"if80000000", 1'b0, 1'b0, 32'h80000000, 32'h0,        32'h0,        1'b1, 0};

        reset_n = 1'b0;
        i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        #1;
        check("reset flags", {26'd0, i_ack, d_ack, i_err, d_err, mem_write_enabled, mem_read_enabled}, 32'd0);
        check("reset i_rdata", i_rdata, 32'h0);
        check("reset d_rdata", d_rdata, 32'h0);
        check("reset mem_address", mem_address, 32'h0);
        #22 reset_n = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("no spurious ack", {30'd0, i_ack, d_ack}, 32'd0);

        for (int n = 0; n < 12; n++) do_access(vecs[n]);
        check("no out-of-range write", 32'(oor_write_count), 32'd0);

        // Contention: a data access first so that last_grant is DATA.
        v = '{"ld5b", 1'b1, 1'b0, 32'd5, 32'h0, 32'hDEADBEEF, 1'b0, 0};
        do_access(v);
        i_req = 1'b1; i_addr = 32'd7;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'd5;
        d_cyc = 0; i_cyc = 0;
        for (int c = 1; c <= 10 && (d_cyc == 0 || i_cyc == 0); c++) begin
            @(negedge clock);
            if (d_ack && d_cyc == 0) begin d_cyc = c; d_req = 1'b0; end
            if (i_ack && i_cyc == 0) begin i_cyc = c; i_req = 1'b0; end
        end
        check("contention d_ack cycle", 32'(d_cyc), DATA_FIRST ? 32'd2 : 32'd5);
        check("contention i_ack cycle", 32'(i_cyc), DATA_FIRST ? 32'd5 : 32'd2);
        check("contention d_rdata", d_rdata, 32'hDEADBEEF);
        check("contention i_rdata", i_rdata, 32'h12345678);
        @(negedge clock);

        // Reset during the ACCESS cycle of a store to word 9.
        wc0 = write_count;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'd9; d_wdata = 32'h55555555;
        @(posedge clock);
        #1;
        check("store access we", {31'd0, mem_write_enabled}, 32'd1);
        check("store access addr", mem_address, 32'd9);
        reset_n = 1'b0;
        #1;
        check("abort flags", {26'd0, i_ack, d_ack, i_err, d_err, mem_write_enabled, mem_read_enabled}, 32'd0);
        check("abort mem_address", mem_address, 32'h0);
        check("abort d_rdata", d_rdata, 32'h0);
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        @(negedge clock);
        #3 reset_n = 1'b1;
        any_ack = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (i_ack || d_ack) any_ack = 1'b1;
        end
        check("no ack after abort", {31'd0, any_ack}, 32'd0);
        check("word 9 unchanged", mem[9], 32'hA5000009);
        check("no write after abort", 32'(write_count - wc0), 32'd0);

        // Service resumes normally after the abort.
        v = '{"if9", 1'b0, 1'b0, 32'd9, 32'h0, 32'hA5000009, 1'b0, 0};
        exp_d_rdata = 32'h0;
        exp_i_rdata = 32'h0;
        do_access(v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-ported word memory.
- Shares the one memory port between the instruction-fetch path (read-only) and the load/store path (read/write).
- Each access runs as a fixed 3-state sequence: the arbiter drives the memory's address, data, write and read enables, then returns read data and an error flag to the winner with a one-cycle ack.
- Sits between the core's fetch/LSU stages and the memory block.

Parameters:
WORD_SIZE, 32, width of address and data words
MEMORY_SIZE, 1024, number of words in the memory; valid addresses are 0..MEMORY_SIZE-1

Ports:
clock  input  1  system clock, rising-edge for all arbiter state
reset_n  input  1  asynchronous active-low reset
i_req  input  1  fetch request; held until i_ack
i_addr  input  WORD_SIZE  fetch word address
i_ack  output  1  one-cycle pulse; i_rdata/i_err valid this cycle
i_rdata  output  WORD_SIZE  fetch read data, registered
i_err  output  1  fetch address out of range, registered
d_req  input  1  load/store request; held until d_ack
d_we  input  1  1 = store, 0 = load; held with d_req
d_addr  input  WORD_SIZE  load/store word address
d_wdata  input  WORD_SIZE  store data
d_ack  output  1  one-cycle pulse; d_rdata/d_err valid this cycle
d_rdata  output  WORD_SIZE  load read data, registered
d_err  output  1  load/store address out of range, registered
mem_write_enabled  output  1  to memory write enable
mem_read_enabled  output  1  to memory read enable
mem_address  output  WORD_SIZE  to memory address
mem_wdata  output  WORD_SIZE  to memory input data
mem_rdata  input  WORD_SIZE  from memory output data (combinational read)

Behaviour:
- Reset (async, reset_n=0): state=IDLE; i_ack=d_ack=0; i_rdata=d_rdata=0; i_err=d_err=0; latched addr/wdata/we=0; last_grant=FETCH. Memory-side outputs are all 0 while in IDLE/DONE.
- Reset mid-ACCESS: the write is aborted immediately (mem_write_enabled drops asynchronously) and no ack is issued.
- FSM: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE: if i_req or d_req is sampled high, select a winner, latch its addr/we/wdata and its id, then go to ACCESS. Otherwise stay in IDLE.
- Arbitration (default): fixed priority, data port wins when both requesters are high.
- ACCESS (exactly 1 cycle):
  - mem_address = latched addr; mem_read_enabled=1.
  - mem_wdata = latched wdata (0 for fetch).
  - mem_write_enabled = latched we AND addr in range AND winner is data port. Fetch never writes.
  - All memory-side outputs are decoded from registers only; they must be stable across the falling edge, where the memory commits the write.
  - At the rising edge ending ACCESS: capture mem_rdata into the winner's rdata register. Capture err = (addr > MEMORY_SIZE-1) into the winner's err register.
  - Out-of-range access: rdata captured as 0, err=1, no write.
  - Store: rdata captured as mem_rdata (the pre-write value).
- DONE (1 cycle): the winner's ack=1; the other ack=0. No arbitration in DONE; the requester that receives the ack deasserts or re-presents its req from the next cycle. Go to IDLE.
- Latency: req sampled at edge k -> ack high during cycle k+2. Throughput: 1 access per 3 cycles.
- The loser's req is held and served in the next IDLE; no request is dropped.
- rdata/err hold their value until that port's next ack.
- Address comparison is unsigned, full WORD_SIZE.
- Changing the address or data while req is high and before ack: the latched values are used.

Optional Feature:
MEM_ARB_ROUND_ROBIN_EN
- Defined: when both reqs are high in IDLE, grant the port that is not last_grant; last_grant updates on every grant. With one requester active, that requester always wins.
- Undefined: fixed data-port priority; the last_grant register is not built. A continuously requesting data port can starve fetch, and this is accepted behaviour.

Test Plan:
- Reset: pulse reset_n low mid-cycle -> all outputs 0 immediately, state IDLE; release -> no spurious ack.
- Store/load: d_req, d_we=1, d_addr=5, d_wdata=32'hDEADBEEF -> d_ack at cycle+2, d_err=0. Then load addr 5 -> d_rdata=32'hDEADBEEF.
- Fetch: preload word 7=32'h12345678; i_req, i_addr=7 -> i_ack at cycle+2, i_rdata=32'h12345678; d_ack stays 0.
- Contention: i_req and d_req high together, held.
  - Without the macro: d_ack, then i_ack 3 cycles later.
  - With the macro and last_grant=DATA: i_ack first.
- Out of range: d_req store to addr 1024, wdata 32'hFFFFFFFF -> d_err=1, d_rdata=0, mem_write_enabled never asserted, no memory word changed.
- Reset during ACCESS of a store to addr 9 -> no d_ack; word 9 unchanged.
